// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED blink sequencer.
// Holds the FSM state encoding, pattern geometry and default timing.
package led_seq_pkg;

  localparam int PAT_W = 16;
  localparam int IDX_W = 4;
  localparam int LEN_W = 5;
  localparam int REP_W = 4;

  localparam int DEF_TICK_DIV  = 2000000;
  localparam int DEF_GAP_TICKS = 4;
  localparam int DEF_CNT_W     = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Index of the last bit to play; lengths of 0 or above 16 mean a full pattern.
  function automatic logic [IDX_W-1:0] last_idx(input logic [LEN_W-1:0] pat_len);
    if (pat_len == '0 || pat_len > LEN_W'(PAT_W)) begin
      return IDX_W'(PAT_W - 1);
    end
    return IDX_W'(pat_len - LEN_W'(1));
  endfunction

endpackage

// File: rtl/led_blink_sequencer_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// clr restarts the count so the next tick is a full period away.
module tick_prescaler #(
  parameter int TICK_DIV = 2000000,
  parameter int CNT_W    = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // tick deliberately ignores clr: clr is derived from the FSM's next state, which itself depends on tick.
  assign tick = en && (cnt_q == CNT_LAST);

  // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink_sequencer.sv
// Plays a latched 16-bit blink pattern MSB-first on the LED, one bit per tick,
// repeating it with an optional dark gap; start/busy/done handshake.
module led_blink_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int GAP_TICKS = DEF_GAP_TICKS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] repeats,
  output logic             busy,
  output logic             done,
  output logic             led
);

  localparam bit HAS_GAP = (GAP_TICKS > 0);
  localparam int GAP_W   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic tick;
  logic presc_en;
  logic presc_clr;

  assign presc_en  = (state_q == ST_PLAY) || (state_q == ST_GAP);
  assign presc_clr = (state_d != state_q);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      last_q    <= '0;
      reps_q    <= '0;
      rep_cnt_q <= '0;
      bit_idx_q <= '0;
      gap_cnt_q <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      last_q    <= last_d;
      reps_q    <= reps_d;
      rep_cnt_q <= rep_cnt_d;
      bit_idx_q <= bit_idx_d;
      gap_cnt_q <= gap_cnt_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    last_d    = last_q;
    reps_d    = reps_q;
    rep_cnt_d = rep_cnt_q;
    bit_idx_d = bit_idx_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          pat_d     = pattern;
          last_d    = last_idx(pat_len);
          reps_d    = repeats;
          rep_cnt_d = repeats;
          bit_idx_d = '0;
          gap_cnt_d = '0;
          state_d   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (bit_idx_q != last_q) begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end else if (reps_q != '0 && rep_cnt_q == REP_W'(1)) begin
            rep_cnt_d = '0;
            state_d   = ST_FINISH;
          end else begin
            // repeats_q == 0 loops forever, so the counter is left alone.
            if (reps_q != '0) begin
              rep_cnt_d = rep_cnt_q - REP_W'(1);
            end
            bit_idx_d = '0;
            if (HAS_GAP) begin
              gap_cnt_d = '0;
              state_d   = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (gap_cnt_q == GAP_LAST) begin
            bit_idx_d = '0;
            state_d   = ST_PLAY;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, giving 1-cycle start-to-LED latency.
  always_comb begin
    led_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      ST_PLAY: begin
        // For a 4-bit index, ~idx == 15 - idx, i.e. MSB-first selection.
        led_d  = pat_d[~bit_idx_d];
        busy_d = 1'b1;
      end
      ST_GAP:    busy_d = 1'b1;
      ST_FINISH: done_d = 1'b1;
      default: begin
        led_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
